alu_pipe: RTL and testbench

Parametrised two-stage register-file/ALU datapath: the successor to the single-cycle 32-bit regfile + ALU + writeback-mux block. Accepts one command per cycle over a valid/ready handshake. Reads two source registers, executes one of eleven ALU ops and optionally writes the result, or an immediate, back to a destination register. Adds pipelining, read-after-write hazard handling, status flags and width/depth generics.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_core.sv | 50 +++++
 rtl/alu_pipe.sv | 130 +++++++++++++
 tb/tb_alu_pipe.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encoding for the ALU datapath.
package alu_pkg;

  localparam int unsigned OP_W = 4;

  typedef logic [OP_W-1:0] aluOp_t;

  localparam aluOp_t OP_ADD = 4'd0;
  localparam aluOp_t OP_SUB = 4'd1;
  localparam aluOp_t OP_AND = 4'd2;
  localparam aluOp_t OP_OR  = 4'd3;
  localparam aluOp_t OP_SLL = 4'd4;
  localparam aluOp_t OP_SRL = 4'd5;
  localparam aluOp_t OP_SRA = 4'd6;
  localparam aluOp_t OP_SGT = 4'd7;
  localparam aluOp_t OP_SLT = 4'd8;
  localparam aluOp_t OP_XOR = 4'd9;
  localparam aluOp_t OP_NOR = 4'd10;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: eleven ops, zero flag and add/sub signed-overflow flag.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  input  logic [SW-1:0]    shamt,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;

  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    result = '0;
    ovf    = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum;
        ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        result = diff;
        ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_SLL: result = a << shamt;
      OP_SRL: result = a >> shamt;
      OP_SRA: result = $unsigned($signed(a) >>> shamt);
      OP_SGT: result = {{(WIDTH-1){1'b0}}, ($signed(a) > $signed(b))};
      OP_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_XOR: result = a ^ b;
      OP_NOR: result = ~(a | b);
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_pipe.sv
// Two-stage regfile/ALU datapath with valid/ready command input.
// Define ALU_FWD_EN to bypass the S2 writeback value instead of stalling on a RAW match.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREGS = 32,
  localparam int AW   = $clog2(NREGS),
  localparam int SW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OP_W-1:0]  cmd_op,
  input  logic [AW-1:0]    cmd_rs1,
  input  logic [AW-1:0]    cmd_rs2,
  input  logic [AW-1:0]    cmd_rd,
  input  logic             cmd_wr,
  input  logic             cmd_sel,
  input  logic [WIDTH-1:0] cmd_imm,
  input  logic [SW-1:0]    cmd_shamt,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             res_zero,
  output logic             res_ovf
);

  logic [WIDTH-1:0] regFile [NREGS];

  logic             s1Valid;
  logic             s1Wr;
  logic             s1Sel;
  logic [WIDTH-1:0] s1A;
  logic [WIDTH-1:0] s1B;
  logic [WIDTH-1:0] s1Imm;
  logic [OP_W-1:0]  s1Op;
  logic [SW-1:0]    s1Shamt;
  logic [AW-1:0]    s1Rd;

  logic [WIDTH-1:0] aluRes;
  logic             aluZero;
  logic             aluOvf;
  logic [WIDTH-1:0] wbData;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             hit1;
  logic             hit2;
  logic             accept;

  alu_core #(
    .WIDTH(WIDTH),
    .SW   (SW)
  ) uCore (
    .a     (s1A),
    .b     (s1B),
    .op    (s1Op),
    .shamt (s1Shamt),
    .result(aluRes),
    .zero  (aluZero),
    .ovf   (aluOvf)
  );

  assign wbData = s1Sel ? s1Imm : aluRes;

  // The S1 command writes the regfile only on the next edge, so its rd is still stale here.
  assign hit1 = s1Valid & s1Wr & (cmd_rs1 == s1Rd);
  assign hit2 = s1Valid & s1Wr & (cmd_rs2 == s1Rd);

`ifdef ALU_FWD_EN
  assign cmd_ready = ~rst;
  assign opA       = hit1 ? wbData : regFile[cmd_rs1];
  assign opB       = hit2 ? wbData : regFile[cmd_rs2];
`else
  assign cmd_ready = ~rst & ~(cmd_valid & (hit1 | hit2));
  assign opA       = regFile[cmd_rs1];
  assign opB       = regFile[cmd_rs2];
`endif

  assign accept = cmd_valid & cmd_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1Valid <= 1'b0;
      s1Wr    <= 1'b0;
      s1Sel   <= 1'b0;
      s1A     <= '0;
      s1B     <= '0;
      s1Imm   <= '0;
      s1Op    <= '0;
      s1Shamt <= '0;
      s1Rd    <= '0;
    end else begin
      s1Valid <= accept;
      if (accept) begin
        s1Wr    <= cmd_wr;
        s1Sel   <= cmd_sel;
        s1A     <= opA;
        s1B     <= opB;
        s1Imm   <= cmd_imm;
        s1Op    <= cmd_op;
        s1Shamt <= cmd_shamt;
        s1Rd    <= cmd_rd;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regFile[i] <= '0;
      end
      res_valid <= 1'b0;
      res_data  <= '0;
      res_zero  <= 1'b0;
      res_ovf   <= 1'b0;
    end else begin
      res_valid <= s1Valid;
      if (s1Valid) begin
        res_data <= wbData;
        res_zero <= aluZero;
        res_ovf  <= aluOvf;
        if (s1Wr) begin
          regFile[s1Rd] <= wbData;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed vector table, mid-op reset and random commands.
module tb_alu_pipe;

`ifdef ALU_FWD_EN
  localparam int HZ = 0;
`else
  localparam int HZ = 1;
`endif
  localparam int NV = 18;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [4:0]  cmd_rs1;
  logic [4:0]  cmd_rs2;
  logic [4:0]  cmd_rd;
  logic        cmd_wr;
  logic        cmd_sel;
  logic [31:0] cmd_imm;
  logic [4:0]  cmd_shamt;
  logic        res_valid;
  logic [31:0] res_data;
  logic        res_zero;
  logic        res_ovf;

  always #5 clk = ~clk;

  alu_pipe #(
    .WIDTH(32),
    .NREGS(32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_rs1  (cmd_rs1),
    .cmd_rs2  (cmd_rs2),
    .cmd_rd   (cmd_rd),
    .cmd_wr   (cmd_wr),
    .cmd_sel  (cmd_sel),
    .cmd_imm  (cmd_imm),
    .cmd_shamt(cmd_shamt),
    .res_valid(res_valid),
    .res_data (res_data),
    .res_zero (res_zero),
    .res_ovf  (res_ovf)
  );

  typedef struct {
    int          due;
    logic [31:0] data;
    bit          zero;
    bit          ovf;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    int          rs1;
    int          rs2;
    int          rd;
    bit          wr;
    bit          sel;
    logic [31:0] imm;
    int          sh;
    logic [31:0] eData;
    bit          eZero;
    bit          eOvf;
    int          eStall;
  } vec_t;

  exp_t        expQ[$];
  exp_t        monE;
  bit          monDue;
  vec_t        vecs[NV];
  logic [31:0] refRegs[32];
  int          cyc = 0;
  int          nCompared = 0;
  int          nFail = 0;
  bit          prevValid;
  bit          prevWr;
  int          prevRd;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference ALU from the opcode definitions, using 64-bit signed arithmetic.
  function automatic void refAlu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input int sh, output logic [31:0] r, output bit z, output bit o);
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s  = 0;
    r  = 32'd0;
    o  = 1'b0;
    case (op)
      4'd0: begin s = sa + sb; r = s[31:0]; o = (s != longint'($signed(r))); end
      4'd1: begin s = sa - sb; r = s[31:0]; o = (s != longint'($signed(r))); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a << sh;
      4'd5: r = a >> sh;
      4'd6: begin s = sa >>> sh; r = s[31:0]; end
      4'd7: r = (sa > sb) ? 32'd1 : 32'd0;
      4'd8: r = (sa < sb) ? 32'd1 : 32'd0;
      4'd9: r = a ^ b;
      4'd10: r = ~(a | b);
      default: r = 32'd0;
    endcase
    z = (r == 32'd0);
  endfunction

  function automatic vec_t mk(input int op, input int rs1, input int rs2, input int rd,
                              input int wr, input int sel, input logic [31:0] imm, input int sh,
                              input logic [31:0] d, input int z, input int o, input int st);
    vec_t v;
    v.op = 4'(op); v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
    v.wr = (wr != 0); v.sel = (sel != 0); v.imm = imm; v.sh = sh;
    v.eData = d; v.eZero = (z != 0); v.eOvf = (o != 0); v.eStall = st;
    return v;
  endfunction

  // Results are due on the negedge two edges after the accepting edge.
  always @(negedge clk) begin
    if (!rst) begin
      monDue = (expQ.size() > 0) && (expQ[0].due == cyc);
      check("res_valid", 32'(res_valid), 32'(monDue));
      if (monDue) begin
        monE = expQ.pop_front();
        if (res_valid) begin
          check("res_data", res_data, monE.data);
          check("res_zero", 32'(res_zero), 32'(monE.zero));
          check("res_ovf", 32'(res_ovf), 32'(monE.ovf));
        end
      end
    end
  end

  task automatic issue(input vec_t v, input bit useExp, output int stalls);
    logic [31:0] r;
    bit z, o;
    exp_t e;
    refAlu(v.op, refRegs[v.rs1], refRegs[v.rs2], v.sh, r, z, o);
    e.data = v.sel ? v.imm : r;
    e.zero = z;
    e.ovf  = o;
    if (useExp) begin
      e.data = v.eData;
      e.zero = v.eZero;
      e.ovf  = v.eOvf;
    end
    cmd_op = v.op; cmd_rs1 = 5'(v.rs1); cmd_rs2 = 5'(v.rs2); cmd_rd = 5'(v.rd);
    cmd_wr = v.wr; cmd_sel = v.sel; cmd_imm = v.imm; cmd_shamt = 5'(v.sh);
    cmd_valid = 1'b1;
    stalls = 0;
    @(negedge clk);
    while (!cmd_ready && stalls < 8) begin
      stalls++;
      @(negedge clk);
    end
    if (!cmd_ready) begin
      check("cmd_ready timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      prevValid = 1'b0;
      return;
    end
    e.due = cyc + 2;
    expQ.push_back(e);
    if (v.wr) refRegs[v.rd] = v.sel ? v.imm : r;
    prevValid = 1'b1;
    prevWr    = v.wr;
    prevRd    = v.rd;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (expQ.size() > 0 && n < 10) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain", 32'(expQ.size()), 32'd0);
    prevValid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   st;
    int   expSt;
    vec_t v;

    vecs[0]  = mk(13, 31, 31, 0, 1, 1, 32'h1, 0, 32'h1, 1, 0, 0);
    vecs[1]  = mk(13, 31, 31, 1, 1, 1, 32'h7, 0, 32'h7, 1, 0, 0);
    vecs[2]  = mk(0, 0, 1, 9, 0, 0, 0, 0, 32'h8, 0, 0, HZ);
    vecs[3]  = mk(1, 0, 1, 9, 0, 0, 0, 0, 32'hFFFF_FFFA, 0, 0, 0);
    vecs[4]  = mk(13, 31, 31, 2, 1, 1, 32'h5, 0, 32'h5, 1, 0, 0);
    vecs[5]  = mk(0, 2, 2, 3, 1, 0, 0, 0, 32'd10, 0, 0, HZ);
    vecs[6]  = mk(13, 31, 31, 4, 1, 1, 32'h7FFF_FFFF, 0, 32'h7FFF_FFFF, 1, 0, 0);
    vecs[7]  = mk(13, 31, 31, 5, 1, 1, 32'h1, 0, 32'h1, 1, 0, 0);
    vecs[8]  = mk(0, 4, 5, 9, 0, 0, 0, 0, 32'h8000_0000, 0, 1, HZ);
    vecs[9]  = mk(8, 4, 5, 9, 0, 0, 0, 0, 32'h0, 1, 0, 0);
    vecs[10] = mk(7, 4, 5, 9, 0, 0, 0, 0, 32'h1, 0, 0, 0);
    vecs[11] = mk(13, 31, 31, 6, 1, 1, 32'h8000_0010, 0, 32'h8000_0010, 1, 0, 0);
    vecs[12] = mk(4, 6, 0, 9, 0, 0, 0, 4, 32'h0000_0100, 0, 0, HZ);
    vecs[13] = mk(5, 6, 0, 9, 0, 0, 0, 4, 32'h0800_0001, 0, 0, 0);
    vecs[14] = mk(6, 6, 0, 9, 0, 0, 0, 4, 32'hF800_0001, 0, 0, 0);
    vecs[15] = mk(13, 31, 31, 6, 1, 0, 32'hDEAD, 0, 32'h0, 1, 0, 0);
    vecs[16] = mk(0, 6, 6, 9, 0, 0, 0, 0, 32'h0, 1, 0, HZ);
    vecs[17] = mk(0, 3, 0, 9, 0, 0, 0, 0, 32'd11, 0, 0, 0);

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_rd = '0;
    cmd_wr = 1'b0; cmd_sel = 1'b0; cmd_imm = '0; cmd_shamt = '0;
    prevValid = 1'b0; prevWr = 1'b0; prevRd = 0;
    for (int i = 0; i < 32; i++) refRegs[i] = 32'd0;

    repeat (2) @(negedge clk);
    check("reset res_valid", 32'(res_valid), 32'd0);
    check("reset res_data", res_data, 32'd0);
    check("reset res_zero", 32'(res_zero), 32'd0);
    check("reset res_ovf", 32'(res_ovf), 32'd0);
    check("reset cmd_ready", 32'(cmd_ready), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      issue(vecs[i], 1'b1, st);
      check($sformatf("vec%0d stall cycles", i), 32'(st), 32'(vecs[i].eStall));
    end
    drain();

    // Reset while a write to r7 sits in S1: it must vanish without trace.
    issue(mk(13, 31, 31, 7, 1, 1, 32'h55, 0, 0, 0, 0, 0), 1'b0, st);
    rst = 1'b1;
    expQ.delete();
    for (int i = 0; i < 32; i++) refRegs[i] = 32'd0;
    prevValid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("mid-reset cmd_ready", 32'(cmd_ready), 32'd0);
      check("mid-reset res_valid", 32'(res_valid), 32'd0);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    issue(mk(0, 7, 0, 8, 0, 0, 0, 0, 32'h0, 1, 0, 0), 1'b1, st);
    check("post-reset stall cycles", 32'(st), 32'd0);
    drain();

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
        prevValid = 1'b0;
      end
      v = mk($urandom_range(0, 15), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 1), $urandom_range(0, 3) == 0,
             $urandom, $urandom_range(0, 31), 0, 0, 0, 0);
      expSt = (HZ != 0 && prevValid && prevWr && (v.rs1 == prevRd || v.rs2 == prevRd)) ? 1 : 0;
      issue(v, 1'b0, st);
      check($sformatf("rand%0d stall cycles", n), 32'(st), 32'(expSt));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFail);
    $finish;
  end

endmodule
